// File: rtl/full_st0_in_ctrl_pkg.sv
// Shared types and default geometry for the stage-0 input sequencer.
//   float_24_8     : 32-bit packed sample (24-bit mantissa, 8-bit exponent)
//   rd_state_e     : read-side FSM state encoding
//   ST0_*          : default widths and frame length used by the stage
package full_st0_in_ctrl_pkg;

  localparam int ST0_DATA_WIDTH = 32;
  localparam int ST0_ADDR_WIDTH = 6;
  localparam int ST0_FRAME_LEN  = 32;
  localparam int ST0_DROP_W     = 8;

  typedef logic [ST0_DATA_WIDTH-1:0] float_24_8;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_BUSY = 1'b1
  } rd_state_e;

endpackage

// File: rtl/full_st0_in_bank_fsm.sv
// Read-side bank tracker for the ping-pong data memory.
// Owns the per-bank full flags, the bank the stage is reading and the
// IDLE/BUSY handshake with the stage.
//   clk, reset   : clock, async active-high reset
//   set_full     : write side completed a bank this cycle
//   set_bank     : which bank was completed
//   read_finish  : stage has consumed the current read bank
//   full[1:0]    : per-bank full flags
//   rd_bank      : bank the stage reads (registered)
//   frame_start  : one-cycle pulse when the read bank becomes ready
//   busy         : stage is reading rd_bank
//
// state   | meaning
// --------+--------------------------------------------------------
// RD_IDLE | waiting for full[rd_bank]; read_finish ignored
// RD_BUSY | stage owns rd_bank; waiting for read_finish to free it
module full_st0_in_bank_fsm
  import full_st0_in_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       set_full,
  input  logic       set_bank,
  input  logic       read_finish,
  output logic [1:0] full,
  output logic       rd_bank,
  output logic       frame_start,
  output logic       busy
);

  rd_state_e state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RD_IDLE;
      full        <= 2'b00;
      rd_bank     <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        RD_IDLE: begin
          if (full[rd_bank]) begin
            frame_start <= 1'b1;
            busy        <= 1'b1;
            state       <= RD_BUSY;
          end
        end
        RD_BUSY: begin
          if (read_finish) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
            busy          <= 1'b0;
            state         <= RD_IDLE;
          end
        end
        default: state <= RD_IDLE;
      endcase
      // Set and clear always target different banks, so both land.
      if (set_full) full[set_bank] <= 1'b1;
    end
  end

  // The write side stalls on a full bank, so it can never complete one.
  a_no_set_on_full: assert property (@(posedge clk) disable iff (reset)
    set_full |-> !full[set_bank]);

endmodule

// File: rtl/full_st0_in_ctrl.sv
// Stage-0 upstream input sequencer.
// Accepts a valid/ready/first sample stream into a two-bank ping-pong data
// memory, issues frame_start per completed bank and frees banks on read_finish.
//   clk, reset              : clock, async active-high reset
//   stage_in/_vld/_fst/_rdy : input sample stream
//   data_value/_write_addr  : data-memory write port, addr = {bank, index}
//   data_valid              : data-memory write strobe (1 cycle after accept)
//   read_finish             : stage done with current read bank
//   frame_start, frame_bank : read bank ready pulse and its bank number
//   busy                    : stage is reading a bank
//   drop_cnt                : saturating count of frames aborted by early fst
module full_st0_in_ctrl
  import full_st0_in_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = ST0_DATA_WIDTH,
  parameter int ADDR_WIDTH = ST0_ADDR_WIDTH,
  parameter int FRAME_LEN  = ST0_FRAME_LEN,
  parameter int DROP_W     = ST0_DROP_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] stage_in,
  input  logic                  stage_in_vld,
  input  logic                  stage_in_fst,
  output logic                  stage_in_rdy,
  output logic [DATA_WIDTH-1:0] data_value,
  output logic [ADDR_WIDTH-1:0] data_write_addr,
  output logic                  data_valid,
  input  logic                  read_finish,
  output logic                  frame_start,
  output logic                  frame_bank,
  output logic                  busy,
  output logic [DROP_W-1:0]     drop_cnt
);

  localparam int IDX_W = ADDR_WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [1:0]       full;
  logic             wr_bank;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] idx_used;
  logic             accept;
  logic             last_sample;
  logic             early_fst;

  // Ready depends only on registered state, never on stage_in_vld.
  assign stage_in_rdy = ~full[wr_bank];
  assign accept       = stage_in_vld & stage_in_rdy;

  // fst restarts the frame at index 0; at index 0 it changes nothing.
  assign idx_used    = stage_in_fst ? '0 : wr_idx;
  assign last_sample = (idx_used == LAST_IDX);
  assign early_fst   = stage_in_fst & (wr_idx != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank         <= 1'b0;
      wr_idx          <= '0;
      data_valid      <= 1'b0;
      data_value      <= '0;
      data_write_addr <= '0;
      drop_cnt        <= '0;
    end else begin
      data_valid <= accept;
      if (accept) begin
        data_value      <= stage_in;
        data_write_addr <= {wr_bank, idx_used};
        if (last_sample) begin
          wr_bank <= ~wr_bank;
          wr_idx  <= '0;
        end else begin
          wr_idx <= idx_used + IDX_W'(1);
        end
        if (early_fst && (drop_cnt != '1)) drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

  full_st0_in_bank_fsm u_bank_fsm (
    .clk         (clk),
    .reset       (reset),
    .set_full    (accept & last_sample),
    .set_bank    (wr_bank),
    .read_finish (read_finish),
    .full        (full),
    .rd_bank     (frame_bank),
    .frame_start (frame_start),
    .busy        (busy)
  );

endmodule

// File: tb/tb_full_st0_in_ctrl.sv
module tb_full_st0_in_ctrl;
  import full_st0_in_ctrl_pkg::*;

  localparam int FL = 32;
  localparam int DROP_MAX = 255;

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  float_24_8 stage_in = '0;
  logic      stage_in_vld = 1'b0;
  logic      stage_in_fst = 1'b0;
  logic      stage_in_rdy;
  float_24_8 data_value;
  logic [5:0] data_write_addr;
  logic      data_valid;
  logic      read_finish = 1'b0;
  logic      frame_start;
  logic      frame_bank;
  logic      busy;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  full_st0_in_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .stage_in        (stage_in),
    .stage_in_vld    (stage_in_vld),
    .stage_in_fst    (stage_in_fst),
    .stage_in_rdy    (stage_in_rdy),
    .data_value      (data_value),
    .data_write_addr (data_write_addr),
    .data_valid      (data_valid),
    .read_finish     (read_finish),
    .frame_start     (frame_start),
    .frame_bank      (frame_bank),
    .busy            (busy),
    .drop_cnt        (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: banks as two full flags, a write cursor as plain ints,
  // and a reader that is either waiting or owns one bank.
  int   m_wr_bank, m_wr_idx, m_rd_bank, m_drops;
  bit   m_full [2];
  bit   m_reading;
  bit   e_valid, e_fs;
  int   e_addr;
  float_24_8 e_value;
  int   idx, done_bank;
  bit   acc, completed;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wr_bank = 0; m_wr_idx = 0; m_rd_bank = 0; m_drops = 0;
      m_full[0] = 0; m_full[1] = 0; m_reading = 0;
      e_valid = 0; e_fs = 0; e_addr = 0; e_value = '0;
    end else begin
      acc = stage_in_vld && !m_full[m_wr_bank];
      e_valid = 0;
      e_fs = 0;
      completed = 0;
      if (acc) begin
        idx = stage_in_fst ? 0 : m_wr_idx;
        if (stage_in_fst && m_wr_idx != 0 && m_drops < DROP_MAX) m_drops++;
        e_valid = 1;
        e_value = stage_in;
        e_addr  = m_wr_bank * FL + idx;
        if (idx == FL - 1) begin
          completed = 1;
          done_bank = m_wr_bank;
          m_wr_bank = 1 - m_wr_bank;
          m_wr_idx  = 0;
        end else begin
          m_wr_idx = idx + 1;
        end
      end
      // Reader reacts to flags as they stood before this edge.
      if (!m_reading) begin
        if (m_full[m_rd_bank]) begin
          e_fs = 1;
          m_reading = 1;
        end
      end else if (read_finish) begin
        m_full[m_rd_bank] = 0;
        m_rd_bank = 1 - m_rd_bank;
        m_reading = 0;
      end
      if (completed) m_full[done_bank] = 1;
    end
  end

  always @(negedge clk) begin
    chk("rdy", {31'b0, stage_in_rdy}, {31'b0, !m_full[m_wr_bank]});
    chk("data_valid", {31'b0, data_valid}, {31'b0, e_valid});
    if (e_valid) begin
      chk("data_value", data_value, e_value);
      chk("data_write_addr", {26'b0, data_write_addr}, 32'(e_addr));
    end
    chk("frame_start", {31'b0, frame_start}, {31'b0, e_fs});
    chk("frame_bank", {31'b0, frame_bank}, 32'(m_rd_bank));
    chk("busy", {31'b0, busy}, {31'b0, m_reading});
    chk("drop_cnt", {24'b0, drop_cnt}, 32'(m_drops));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input float_24_8 d, input logic fst);
    stage_in = d;
    stage_in_fst = fst;
    stage_in_vld = 1'b1;
    tick();
    stage_in_vld = 1'b0;
    stage_in_fst = 1'b0;
  endtask

  task automatic pulse_finish();
    read_finish = 1'b1;
    tick();
    read_finish = 1'b0;
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;

    // Frame 0 into bank 0, no back-pressure.
    for (int i = 0; i < FL; i++) begin
      stage_in = 32'h3F80_0000 + 32'(i);
      stage_in_fst = (i == 0);
      stage_in_vld = 1'b1;
      tick();
      if (i == 0) begin
        chk("lit_first_addr", {26'b0, data_write_addr}, 32'd0);
        chk("lit_first_value", data_value, 32'h3F80_0000);
      end
    end
    stage_in_vld = 1'b0;
    stage_in_fst = 1'b0;
    chk("lit_last_addr", {26'b0, data_write_addr}, 32'd31);
    chk("lit_last_value", data_value, 32'h3F80_001F);
    chk("lit_no_early_fs", {31'b0, frame_start}, 32'd0);
    tick();
    chk("lit_fs0", {31'b0, frame_start}, 32'd1);
    chk("lit_fs0_bank", {31'b0, frame_bank}, 32'd0);

    // Bank 1 with read_finish withheld, then a 65th offered sample.
    for (int i = 0; i < FL; i++) send(32'h4000_0000 + 32'(i), i == 0);
    chk("lit_last_addr_b1", {26'b0, data_write_addr}, 32'd63);
    chk("lit_rdy_both_full", {31'b0, stage_in_rdy}, 32'd0);
    stage_in = 32'hDEAD_BEEF;
    stage_in_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lit_no_strobe_stalled", {31'b0, data_valid}, 32'd0);
    end
    stage_in_vld = 1'b0;

    pulse_finish();
    chk("lit_busy_drop", {31'b0, busy}, 32'd0);
    chk("lit_rdy_back", {31'b0, stage_in_rdy}, 32'd1);
    tick();
    chk("lit_fs1", {31'b0, frame_start}, 32'd1);
    chk("lit_fs1_bank", {31'b0, frame_bank}, 32'd1);
    pulse_finish();

    // Early fst at index 10.
    for (int i = 0; i < 10; i++) send(32'h1000 + 32'(i), i == 0);
    send(32'h2000, 1'b1);
    chk("lit_abort_addr", {26'b0, data_write_addr}, 32'd0);
    chk("lit_drop1", {24'b0, drop_cnt}, 32'd1);
    for (int i = 1; i < FL; i++) send(32'h2000 + 32'(i), 1'b0);
    chk("lit_abort_last_addr", {26'b0, data_write_addr}, 32'd31);
    tick();
    chk("lit_fs_after_abort", {31'b0, frame_start}, 32'd1);
    pulse_finish();

    // Saturation of the drop counter.
    for (int k = 0; k < 260; k++) begin
      send($urandom, 1'b0);
      send($urandom, 1'b1);
    end
    chk("lit_drop_sat", {24'b0, drop_cnt}, 32'd255);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      stage_in     = $urandom;
      stage_in_vld = ($urandom_range(0, 3) != 0);
      stage_in_fst = ($urandom_range(0, 31) == 0);
      read_finish  = ($urandom_range(0, 7) == 0);
      tick();
    end
    stage_in_vld = 1'b0;
    stage_in_fst = 1'b0;
    read_finish  = 1'b0;

    // Reset mid-BUSY with bank 1 half written.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < FL; i++) send(32'h5000 + 32'(i), i == 0);
    tick();
    chk("lit_busy_before_reset", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 5; i++) send(32'h6000 + 32'(i), i == 0);
    send(32'h7000, 1'b1);
    for (int i = 1; i < 16; i++) send(32'h7000 + 32'(i), 1'b0);
    chk("lit_drop_before_reset", {24'b0, drop_cnt}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("lit_rst_valid", {31'b0, data_valid}, 32'd0);
    chk("lit_rst_addr", {26'b0, data_write_addr}, 32'd0);
    chk("lit_rst_value", data_value, 32'd0);
    chk("lit_rst_fs", {31'b0, frame_start}, 32'd0);
    chk("lit_rst_bank", {31'b0, frame_bank}, 32'd0);
    chk("lit_rst_busy", {31'b0, busy}, 32'd0);
    chk("lit_rst_drop", {24'b0, drop_cnt}, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < FL; i++) send(32'h3F80_0000 + 32'(i), i == 0);
    chk("lit_post_rst_last_addr", {26'b0, data_write_addr}, 32'd31);
    tick();
    chk("lit_post_rst_fs", {31'b0, frame_start}, 32'd1);
    chk("lit_post_rst_bank", {31'b0, frame_bank}, 32'd0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/full_st0_in_ctrl.md
Name: full_st0_in_ctrl

Overview:
- Upstream input sequencer for the stage-0 control/output block.
- Accepts a valid/ready/first stream of float_24_8 samples into a 64-entry ping-pong data memory as two 32-entry banks.
- Drives the stage's data-memory write side (data_value, data_write_addr, data_valid).
- Issues a one-cycle frame start per completed bank and frees the bank when the stage reports read_finish.

Parameters:
- DATA_WIDTH, 32, sample width in bits (float_24_8).
- ADDR_WIDTH, 6, data-memory address width; bank select is the MSB.
- FRAME_LEN, 32, samples per frame; must equal 2**(ADDR_WIDTH-1).
- DROP_W, 8, width of the dropped-frame counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- stage_in  in  DATA_WIDTH  input sample.
- stage_in_vld  in  1  sample valid.
- stage_in_fst  in  1  sample is the first of a frame.
- stage_in_rdy  out  1  block can accept a sample.
- data_value  out  DATA_WIDTH  data-memory write data.
- data_write_addr  out  ADDR_WIDTH  data-memory write address {bank, index}.
- data_valid  out  1  data-memory write strobe.
- read_finish  in  1  stage has consumed the current read bank (1-cycle pulse).
- frame_start  out  1  one-cycle pulse: read bank is full and ready.
- frame_bank  out  1  bank the stage must read (read address MSB).
- busy  out  1  read FSM is in BUSY.
- drop_cnt  out  DROP_W  saturating count of frames aborted by an early fst.

Behaviour:
- Reset: clk and reset as named; reset is asynchronous and active-high. All registers and outputs clear to 0: full[1:0]=0, wr_bank=0, wr_idx=0, rd_bank=0, state=IDLE, drop_cnt=0, data_valid=0, frame_start=0.
- Handshake: stage_in_rdy = ~full[wr_bank], driven from registers only, with no combinational path from stage_in_vld. A sample is accepted when stage_in_vld & stage_in_rdy.
- Write pipeline, one-cycle latency: the cycle after acceptance, data_valid=1, data_value=stage_in, data_write_addr={wr_bank, idx_used}.
  - idx_used = 0 if stage_in_fst, else wr_idx.
- Index update on acceptance: wr_idx <= idx_used+1.
  - If idx_used == FRAME_LEN-1: full[wr_bank] is set in the same edge that registers the write; wr_bank toggles; wr_idx <= 0.
- Early fst (stage_in_fst with wr_idx != 0): the partial frame is discarded by rewriting from index 0 in the same bank, and drop_cnt increments, saturating at all-ones.
- fst is ignored when wr_idx == 0. Samples without fst at wr_idx == 0 are accepted as frame start, so fst is optional.
- Read FSM has two states, IDLE and BUSY.
  - IDLE: if full[rd_bank], pulse frame_start for 1 cycle and go to BUSY. This fires at earliest one cycle after the last write strobe, so the last write has landed.
  - BUSY: on read_finish, clear full[rd_bank], toggle rd_bank, go to IDLE.
  - read_finish in IDLE is ignored.
- frame_bank = rd_bank, registered.
- Simultaneous events:
  - Last-sample set of full[x] and read_finish clear of full[y] (x != y) in the same cycle: both take effect.
  - x == y cannot occur because the write side stalls on a full bank; an assertion covers it.
- Back-to-back frames: the BUSY→IDLE→frame_start gap is at most 2 cycles when the next bank is already full.
- Both banks full: stage_in_rdy=0 until read_finish. rdy rises the cycle after the full bit clears.
- Reset mid-frame or mid-BUSY: everything asynchronously returns to reset values, and partial data is abandoned.
- Width rules: wr_idx is ADDR_WIDTH-1 bits and wraps only via the explicit FRAME_LEN-1 compare. No arithmetic on sample data.

Decomposition:
- Shared types package: float_24_8 typedef plus the FRAME_LEN/ADDR_WIDTH defaults used by the stage.
- One sub-module, full_st0_in_bank_fsm: the read-side IDLE/BUSY FSM, full[1:0] and rd_bank. It takes set_full/set_bank from the write side.
- Write counter and write pipeline stay in the top module.

Test Plan:
- Reset, then 32 samples 0x3F800000+i with no back-pressure → 32 data_valid strobes at addr 0..31, each one cycle after acceptance; frame_start one cycle after the last strobe; frame_bank=0.
- 64 samples with read_finish withheld → addrs 0..63 written; stage_in_rdy=0 from the cycle after the 64th sample; no strobes on a 65th offered sample.
- Continue the previous case with read_finish → busy drops; stage_in_rdy=1 next cycle; second frame_start within 2 cycles with frame_bank=1.
- fst at index 10 of frame 0 → the next write goes to addr 0; drop_cnt=1; frame_start only after 32 more samples.
- 260 early-fst aborts → drop_cnt saturates at 255.
- Assert reset mid-BUSY while bank 1 is half written → all outputs 0 immediately. After release, a fresh 32-sample frame writes addrs 0..31 and pulses frame_start with frame_bank=0.
